// File: rtl/qspi_bus_arbiter.sv
// Two-port arbiter for a shared QSPI SRAM: grants the pads to the boot loader
// (port 0) or the SoC controller (port 1), and forces idle guard cycles between owners.
module qspi_bus_arbiter #(
    parameter int GUARD_CYCLES = 2,
    parameter int ROUND_ROBIN  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req0,
    input  logic       i_req1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    input  logic       i_cs0_n,
    input  logic       i_sck0,
    input  logic       i_sio_oe0,
    input  logic       i_cs1_n,
    input  logic       i_sck1,
    input  logic       i_sio_oe1,
    input  logic [3:0] i_sio0_o,
    input  logic [3:0] i_sio1_o,
    output logic [3:0] o_sio_i,
    output logic       o_mem_cs_n,
    output logic       o_mem_sck,
    output logic       o_mem_sio_oe,
    output logic [3:0] o_mem_sio_o,
    input  logic [3:0] i_mem_sio_i,
    output logic       o_owner,
    output logic       o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN0  = 2'd1;
    localparam logic [1:0] S_OWN1  = 2'd2;
    localparam logic [1:0] S_GUARD = 2'd3;

    // With no guard cycles configured, a released owner drops straight back to IDLE.
    localparam logic [1:0] S_EXIT       = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
    localparam logic [3:0] GUARD_LOAD   = (GUARD_CYCLES > 0) ? 4'(GUARD_CYCLES - 1) : 4'd0;
    localparam bit         RR_EN        = (ROUND_ROBIN != 0);

    logic [1:0] r_state;
    logic [3:0] r_guard;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_owner;
    logic       r_busy;

    logic [1:0] w_state_nxt;
    logic [3:0] w_guard_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_guard_nxt = r_guard;
        case (r_state)
            S_IDLE: begin
                if (i_req0 && i_req1) begin
                    w_state_nxt = (RR_EN && !r_owner) ? S_OWN1 : S_OWN0;
                end else if (i_req0) begin
                    w_state_nxt = S_OWN0;
                end else if (i_req1) begin
                    w_state_nxt = S_OWN1;
                end
            end
            // Release only once the owner has both dropped req and deasserted CS,
            // so an in-flight SPI transaction is never cut short.
            S_OWN0: begin
                if (!i_req0 && i_cs0_n) begin
                    w_state_nxt = S_EXIT;
                    w_guard_nxt = GUARD_LOAD;
                end
            end
            S_OWN1: begin
                if (!i_req1 && i_cs1_n) begin
                    w_state_nxt = S_EXIT;
                    w_guard_nxt = GUARD_LOAD;
                end
            end
            S_GUARD: begin
                if (r_guard == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_guard_nxt = r_guard - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_guard <= 4'd0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_owner <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_guard <= w_guard_nxt;
            r_gnt0  <= (w_state_nxt == S_OWN0);
            r_gnt1  <= (w_state_nxt == S_OWN1);
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_state_nxt == S_OWN0) begin
                r_owner <= 1'b0;
            end else if (w_state_nxt == S_OWN1) begin
                r_owner <= 1'b1;
            end
        end
    end

    always_comb begin
        o_mem_cs_n   = 1'b1;
        o_mem_sck    = 1'b0;
        o_mem_sio_oe = 1'b0;
        o_mem_sio_o  = 4'd0;
        case (r_state)
            S_OWN0: begin
                o_mem_cs_n   = i_cs0_n;
                o_mem_sck    = i_sck0;
                o_mem_sio_oe = i_sio_oe0;
                o_mem_sio_o  = i_sio0_o;
            end
            S_OWN1: begin
                o_mem_cs_n   = i_cs1_n;
                o_mem_sck    = i_sck1;
                o_mem_sio_oe = i_sio_oe1;
                o_mem_sio_o  = i_sio1_o;
            end
            default: ;
        endcase
    end

    assign o_sio_i = i_mem_sio_i;
    assign o_gnt0  = r_gnt0;
    assign o_gnt1  = r_gnt1;
    assign o_owner = r_owner;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: three instances (round-robin, fixed priority, zero guard)
// with shared SPI-side inputs and per-instance request lines.
module tb_qspi_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] req0, req1;
    logic       cs0_n, sck0, oe0, cs1_n, sck1, oe1;
    logic [3:0] sio0_o, sio1_o, mem_sio_i;
    logic [2:0] gnt0, gnt1, owner, busy, mcs, msck, moe;
    logic [3:0] msio [3];
    logic [3:0] sio_i [3];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q [$];

    qspi_bus_arbiter #(.GUARD_CYCLES(2), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset(reset), .i_req0(req0[0]), .i_req1(req1[0]),
        .o_gnt0(gnt0[0]), .o_gnt1(gnt1[0]),
        .i_cs0_n(cs0_n), .i_sck0(sck0), .i_sio_oe0(oe0),
        .i_cs1_n(cs1_n), .i_sck1(sck1), .i_sio_oe1(oe1),
        .i_sio0_o(sio0_o), .i_sio1_o(sio1_o), .o_sio_i(sio_i[0]),
        .o_mem_cs_n(mcs[0]), .o_mem_sck(msck[0]), .o_mem_sio_oe(moe[0]),
        .o_mem_sio_o(msio[0]), .i_mem_sio_i(mem_sio_i),
        .o_owner(owner[0]), .o_busy(busy[0])
    );

    qspi_bus_arbiter #(.GUARD_CYCLES(2), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .reset(reset), .i_req0(req0[1]), .i_req1(req1[1]),
        .o_gnt0(gnt0[1]), .o_gnt1(gnt1[1]),
        .i_cs0_n(cs0_n), .i_sck0(sck0), .i_sio_oe0(oe0),
        .i_cs1_n(cs1_n), .i_sck1(sck1), .i_sio_oe1(oe1),
        .i_sio0_o(sio0_o), .i_sio1_o(sio1_o), .o_sio_i(sio_i[1]),
        .o_mem_cs_n(mcs[1]), .o_mem_sck(msck[1]), .o_mem_sio_oe(moe[1]),
        .o_mem_sio_o(msio[1]), .i_mem_sio_i(mem_sio_i),
        .o_owner(owner[1]), .o_busy(busy[1])
    );

    qspi_bus_arbiter #(.GUARD_CYCLES(0), .ROUND_ROBIN(1)) u_g0 (
        .clk(clk), .reset(reset), .i_req0(req0[2]), .i_req1(req1[2]),
        .o_gnt0(gnt0[2]), .o_gnt1(gnt1[2]),
        .i_cs0_n(cs0_n), .i_sck0(sck0), .i_sio_oe0(oe0),
        .i_cs1_n(cs1_n), .i_sck1(sck1), .i_sio_oe1(oe1),
        .i_sio0_o(sio0_o), .i_sio1_o(sio1_o), .o_sio_i(sio_i[2]),
        .o_mem_cs_n(mcs[2]), .o_mem_sck(msck[2]), .o_mem_sio_oe(moe[2]),
        .o_mem_sio_o(msio[2]), .i_mem_sio_i(mem_sio_i),
        .o_owner(owner[2]), .o_busy(busy[2])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req0 = 3'b000; req1 = 3'b000;
        cs0_n = 1'b1; cs1_n = 1'b1;
        sck0 = 1'b0; sck1 = 1'b0; oe0 = 1'b0; oe1 = 1'b0;
        sio0_o = 4'h0; sio1_o = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        mem_sio_i = 4'h9;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (gnt0[k] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0[%0d]: got %b want 0", k, gnt0[k]); end
            n_checks++; if (gnt1[k] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1[%0d]: got %b want 0", k, gnt1[k]); end
            n_checks++; if (owner[k] !== 1'b1) begin n_fail++; $display("FAIL reset_owner[%0d]: got %b want 1", k, owner[k]); end
            n_checks++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
            n_checks++; if (mcs[k] !== 1'b1) begin n_fail++; $display("FAIL reset_mem_cs_n[%0d]: got %b want 1", k, mcs[k]); end
            n_checks++; if (msck[k] !== 1'b0 || moe[k] !== 1'b0 || msio[k] !== 4'h0) begin
                n_fail++; $display("FAIL reset_mem_pins[%0d]: got sck=%b oe=%b sio=%h want 0/0/0", k, msck[k], moe[k], msio[k]);
            end
            n_checks++; if (sio_i[k] !== 4'h9) begin n_fail++; $display("FAIL idle_sio_i[%0d]: got %h want 9", k, sio_i[k]); end
        end
    endtask

    task automatic test_tie;
        req0[0] = 1'b1; req1[0] = 1'b1;
        tick();
        n_checks++; if (gnt0[0] !== 1'b1) begin n_fail++; $display("FAIL tie_gnt0: got %b want 1", gnt0[0]); end
        n_checks++; if (gnt1[0] !== 1'b0) begin n_fail++; $display("FAIL tie_gnt1: got %b want 0", gnt1[0]); end
        n_checks++; if (owner[0] !== 1'b0) begin n_fail++; $display("FAIL tie_owner: got %b want 0", owner[0]); end
        n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL tie_busy: got %b want 1", busy[0]); end
    endtask

    task automatic test_hold_release;
        cs0_n = 1'b0; req0[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (gnt0[0] !== 1'b1) begin n_fail++; $display("FAIL hold_gnt0 cycle %0d: got %b want 1", i, gnt0[0]); end
            n_checks++; if (mcs[0] !== 1'b0) begin n_fail++; $display("FAIL hold_mem_cs_n cycle %0d: got %b want 0", i, mcs[0]); end
        end
        cs0_n = 1'b1; sck0 = 1'b1; oe0 = 1'b1; sio0_o = 4'hF;
        tick();
        n_checks++; if (gnt0[0] !== 1'b0) begin n_fail++; $display("FAIL guard1_gnt0: got %b want 0", gnt0[0]); end
        n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL guard1_busy: got %b want 1", busy[0]); end
        n_checks++; if (mcs[0] !== 1'b1 || msck[0] !== 1'b0 || moe[0] !== 1'b0 || msio[0] !== 4'h0) begin
            n_fail++; $display("FAIL guard1_mem_pins: got cs_n=%b sck=%b oe=%b sio=%h want 1/0/0/0", mcs[0], msck[0], moe[0], msio[0]);
        end
        tick();
        n_checks++; if (mcs[0] !== 1'b1 || gnt1[0] !== 1'b0) begin
            n_fail++; $display("FAIL guard2: got cs_n=%b gnt1=%b want 1/0", mcs[0], gnt1[0]);
        end
        tick();
        n_checks++; if (gnt1[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_guard: got gnt1=%b busy=%b want 0/0", gnt1[0], busy[0]);
        end
        tick();
        n_checks++; if (gnt1[0] !== 1'b1) begin n_fail++; $display("FAIL handoff_gnt1: got %b want 1", gnt1[0]); end
        n_checks++; if (owner[0] !== 1'b1) begin n_fail++; $display("FAIL handoff_owner: got %b want 1", owner[0]); end
        sck0 = 1'b0; oe0 = 1'b0; sio0_o = 4'h0;
    endtask

    task automatic test_mux;
        cs1_n = 1'b0; sio1_o = 4'hA; oe1 = 1'b1; sck1 = 1'b0;
        cs0_n = 1'b1; sio0_o = 4'h5; oe0 = 1'b0; sck0 = 1'b1;
        mem_sio_i = 4'h3;
        #1;
        n_checks++; if (mcs[0] !== 1'b0 || moe[0] !== 1'b1 || msio[0] !== 4'hA) begin
            n_fail++; $display("FAIL mux_own1: got cs_n=%b oe=%b sio=%h want 0/1/A", mcs[0], moe[0], msio[0]);
        end
        n_checks++; if (sio_i[0] !== 4'h3) begin n_fail++; $display("FAIL mux_sio_i: got %h want 3", sio_i[0]); end
        for (int i = 0; i < 4; i++) begin
            sck1 = ~sck1; sck0 = ~sck1;
            #1;
            n_checks++; if (msck[0] !== sck1) begin n_fail++; $display("FAIL mux_sck toggle %0d: got %b want %b", i, msck[0], sck1); end
            tick();
        end
        cs1_n = 1'b1; req1[0] = 1'b0; oe1 = 1'b0; sio1_o = 4'h0; sck1 = 1'b0; sck0 = 1'b0; sio0_o = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_own;
        do_reset();
        req0[0] = 1'b1;
        tick();
        cs0_n = 1'b0; sck0 = 1'b1; oe0 = 1'b1; sio0_o = 4'hF;
        #1;
        n_checks++; if (mcs[0] !== 1'b0 || gnt0[0] !== 1'b1) begin
            n_fail++; $display("FAIL midown_setup: got cs_n=%b gnt0=%b want 0/1", mcs[0], gnt0[0]);
        end
        reset = 1'b1;
        tick();
        n_checks++; if (gnt0[0] !== 1'b0) begin n_fail++; $display("FAIL midown_gnt0: got %b want 0", gnt0[0]); end
        n_checks++; if (mcs[0] !== 1'b1 || msck[0] !== 1'b0 || moe[0] !== 1'b0) begin
            n_fail++; $display("FAIL midown_mem_pins: got cs_n=%b sck=%b oe=%b want 1/0/0", mcs[0], msck[0], moe[0]);
        end
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midown_busy: got %b want 0", busy[0]); end
        n_checks++; if (owner[0] !== 1'b1) begin n_fail++; $display("FAIL midown_owner: got %b want 1", owner[0]); end
        reset = 1'b0;
        req0[0] = 1'b0; cs0_n = 1'b1; sck0 = 1'b0; oe0 = 1'b0; sio0_o = 4'h0;
    endtask

    task automatic test_arbitration(input int k, input int rr);
        int got;
        int e;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back((rr != 0) ? (i % 2) : 0);
        do_reset();
        req0[k] = 1'b1; req1[k] = 1'b1;
        while (exp_q.size() > 0) begin
            got = -1;
            for (int c = 0; c < 20 && got < 0; c++) begin
                tick();
                if (gnt0[k] === 1'b1) got = 0;
                else if (gnt1[k] === 1'b1) got = 1;
            end
            e = exp_q.pop_front();
            n_checks++; if (got != e) begin n_fail++; $display("FAIL arb inst%0d rr=%0d: granted port %0d want %0d", k, rr, got, e); end
            n_checks++; if ((gnt0[k] & gnt1[k]) !== 1'b0) begin n_fail++; $display("FAIL arb_exclusive inst%0d: gnt0=%b gnt1=%b", k, gnt0[k], gnt1[k]); end
            if (got < 0) break;
            if (got == 0) req0[k] = 1'b0; else req1[k] = 1'b0;
            tick();
            req0[k] = 1'b1; req1[k] = 1'b1;
        end
        req0[k] = 1'b0; req1[k] = 1'b0;
    endtask

    task automatic test_guard0;
        do_reset();
        req0[2] = 1'b1;
        tick();
        n_checks++; if (gnt0[2] !== 1'b1) begin n_fail++; $display("FAIL g0_gnt0: got %b want 1", gnt0[2]); end
        req0[2] = 1'b0; req1[2] = 1'b1;
        tick();
        n_checks++; if (gnt0[2] !== 1'b0 || gnt1[2] !== 1'b0) begin
            n_fail++; $display("FAIL g0_idle_gnts: got gnt0=%b gnt1=%b want 0/0", gnt0[2], gnt1[2]);
        end
        n_checks++; if (busy[2] !== 1'b0 || mcs[2] !== 1'b1) begin
            n_fail++; $display("FAIL g0_idle_state: got busy=%b cs_n=%b want 0/1", busy[2], mcs[2]);
        end
        tick();
        n_checks++; if (gnt1[2] !== 1'b1 || owner[2] !== 1'b1) begin
            n_fail++; $display("FAIL g0_gnt1: got gnt1=%b owner=%b want 1/1", gnt1[2], owner[2]);
        end
        req1[2] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        mem_sio_i = 4'h0;
        test_reset();
        test_tie();
        test_hold_release();
        test_mux();
        test_reset_mid_own();
        test_arbitration(0, 1);
        test_arbitration(1, 0);
        test_guard0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
